// File: rtl/result_readback_ctrl.sv
// Streams result BRAM words to a byte transmitter as a framed packet:
// 0xA5 header, each word LSB first, then an XOR checksum of the data bytes.
module result_readback_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_SIZE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD =
    ADDR_WIDTH'(OUT_SIZE - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_WAIT,
    S_SEND,
    S_CSUM,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [7:0]            csum_q, csum_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
    end
  end

  assign rd_addr = wcnt_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    csum_d   = csum_q;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          wcnt_d  = '0;
          bcnt_d  = '0;
          csum_d  = '0;
        end
      end
      S_HDR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        if (tx_ready) state_d = S_RD;
      end
      S_RD: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        word_d  = rd_data;
        bcnt_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
        if (tx_ready) begin
          csum_d = csum_q ^ word_q[7:0];
          word_d = word_q >> 8;
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d = '0;
            // Hold the counter on the last word so it never wraps.
            if (wcnt_q == LAST_WORD) begin
              state_d = S_CSUM;
            end else begin
              wcnt_d  = wcnt_q + 1'b1;
              state_d = S_RD;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_CSUM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_d = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
